// File: rtl/states_pkg.sv
// Shared UART FSM state encoding plus small sizing helpers.
// Common to the transmitter and the receiver.
package states_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // A counter always needs at least one bit, even when it only ever holds 0.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Handshake and serial-line bundle for uart_tx.
// The DUT modport is the transmitter side; master is the producer of data and ticks.
interface uart_tx_IF #(
  parameter int DBIT      = 8,
  parameter int BIT_WIDTH = 16,
  parameter int SB_TICK   = 16
) ();

  logic            s_tick;
  logic            tx_start;
  logic [DBIT-1:0] din;
  logic            tx;
  logic            tx_done;
  logic            tx_busy;

  modport DUT (
    input  s_tick, tx_start, din,
    output tx, tx_done, tx_busy
  );

  modport master (
    output s_tick, tx_start, din,
    input  tx, tx_done, tx_busy
  );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: START, DATA (LSB first), optional PARITY, STOP, paced by an external s_tick.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx
  import states_pkg::*;
#(
  parameter int DBIT      = 8,
  parameter int BIT_WIDTH = 16,
  parameter int SB_TICK   = 16
) (
  input logic    clk,
  input logic    rst_n,
  uart_tx_IF.DUT bus
);

  localparam int SW = cnt_width(max_int(BIT_WIDTH, SB_TICK));
  localparam int NW = cnt_width(DBIT);
  localparam logic [SW-1:0] BIT_LAST  = SW'(BIT_WIDTH - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] DATA_LAST = NW'(DBIT - 1);

  state_e          state;
  logic [SW-1:0]   s_cnt;
  logic [NW-1:0]   n_cnt;
  logic [DBIT-1:0] b_reg;
  logic [DBIT-1:0] b_next;
  logic            tx_line;
  logic            done_pulse;
  logic            bit_end;
  logic            stop_end;
`ifdef UART_TX_PARITY_EN
  logic            parity;
`endif

  assign b_next   = b_reg >> 1;
  assign bit_end  = bus.s_tick && (s_cnt == BIT_LAST);
  assign stop_end = bus.s_tick && (s_cnt == STOP_LAST);

  assign bus.tx      = tx_line;
  assign bus.tx_done = done_pulse;
  assign bus.tx_busy = (state != IDLE);

  // tx is loaded with the level of the state being entered, so the line changes
  // on the same edge as the state and never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx_line    <= 1'b1;
      done_pulse <= 1'b0;
      s_cnt      <= '0;
      n_cnt      <= '0;
      b_reg      <= '0;
`ifdef UART_TX_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      done_pulse <= 1'b0;
      case (state)
        IDLE: begin
          tx_line <= 1'b1;
          if (bus.tx_start) begin
            state   <= START;
            tx_line <= 1'b0;
            b_reg   <= bus.din;
            s_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
            parity  <= ^bus.din;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            tx_line <= b_reg[0];
            s_cnt   <= '0;
            n_cnt   <= '0;
          end else if (bus.s_tick) begin
            s_cnt <= s_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            s_cnt <= '0;
            b_reg <= b_next;
            if (n_cnt == DATA_LAST) begin
              n_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              tx_line <= parity;
`else
              state   <= STOP;
              tx_line <= 1'b1;
`endif
            end else begin
              n_cnt   <= n_cnt + 1'b1;
              tx_line <= b_next[0];
            end
          end else if (bus.s_tick) begin
            s_cnt <= s_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state   <= STOP;
            tx_line <= 1'b1;
            s_cnt   <= '0;
          end else if (bus.s_tick) begin
            s_cnt <= s_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          tx_line <= 1'b1;
          if (stop_end) begin
            state      <= IDLE;
            done_pulse <= 1'b1;
            s_cnt      <= '0;
          end else if (bus.s_tick) begin
            s_cnt <= s_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          tx_line <= 1'b1;
          s_cnt   <= '0;
          n_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a segment-queue line model checked every cycle,
// plus directed frames with hand-computed bit patterns and frame lengths.
module tb_uart_tx;

  localparam int DBIT = 8;
  localparam int BW   = 16;
  localparam int SBT  = 16;

  // Expected line levels per bit period, bit 0 = start bit.
`ifdef UART_TX_PARITY_EN
  localparam int NBITS      = 11;
  localparam int FRAME_CLKS = 176;
  localparam int SLOW_CLKS  = 704;
  localparam logic [10:0] BITS_A5 = 11'b1_0_10100101_0;
  localparam logic [10:0] BITS_00 = 11'b1_0_00000000_0;
  localparam logic [10:0] BITS_07 = 11'b1_1_00000111_0;
  localparam logic [10:0] BITS_FF = 11'b1_0_11111111_0;
  localparam logic [10:0] BITS_5A = 11'b1_0_01011010_0;
`else
  localparam int NBITS      = 10;
  localparam int FRAME_CLKS = 160;
  localparam int SLOW_CLKS  = 640;
  localparam logic [10:0] BITS_A5 = 11'b0_1_10100101_0;
  localparam logic [10:0] BITS_00 = 11'b0_1_00000000_0;
  localparam logic [10:0] BITS_07 = 11'b0_1_00000111_0;
  localparam logic [10:0] BITS_FF = 11'b0_1_11111111_0;
  localparam logic [10:0] BITS_5A = 11'b0_1_01011010_0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   tick_div = 1;
  int   tick_cnt = 0;

  uart_tx_IF #(.DBIT(DBIT), .BIT_WIDTH(BW), .SB_TICK(SBT)) bus ();

  uart_tx #(.DBIT(DBIT), .BIT_WIDTH(BW), .SB_TICK(SBT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    bus.s_tick = (tick_cnt == 0);
    tick_cnt   = (tick_cnt + 1 >= tick_div) ? 0 : tick_cnt + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Line model: an accepted frame becomes a queue of (level, ticks) segments that
  // drain one s_tick at a time; the frame ends when the queue empties.
  int   seg_lvl[$];
  int   seg_len[$];
  logic exp_tx, exp_done, exp_busy;

  always @(posedge clk) begin
    logic       st;
    logic       tk;
    logic [7:0] d;
    st = bus.tx_start;
    tk = bus.s_tick;
    d  = bus.din;
    #1;
    exp_done = 1'b0;
    if (!rst_n) begin
      seg_lvl.delete();
      seg_len.delete();
    end else if (seg_len.size() == 0) begin
      if (st) begin
        seg_lvl.push_back(0);
        seg_len.push_back(BW);
        for (int i = 0; i < DBIT; i++) begin
          seg_lvl.push_back(int'(d[i]));
          seg_len.push_back(BW);
        end
`ifdef UART_TX_PARITY_EN
        seg_lvl.push_back(int'(^d));
        seg_len.push_back(BW);
`endif
        seg_lvl.push_back(1);
        seg_len.push_back(SBT);
      end
    end else if (tk) begin
      seg_len[0] = seg_len[0] - 1;
      if (seg_len[0] == 0) begin
        void'(seg_lvl.pop_front());
        void'(seg_len.pop_front());
        if (seg_len.size() == 0) exp_done = 1'b1;
      end
    end
    exp_busy = (seg_len.size() != 0);
    exp_tx   = exp_busy ? (seg_lvl[0] != 0) : 1'b1;
    checkOutput("model_tx",      {31'd0, bus.tx},      {31'd0, exp_tx});
    checkOutput("model_tx_done", {31'd0, bus.tx_done}, {31'd0, exp_done});
    checkOutput("model_tx_busy", {31'd0, bus.tx_busy}, {31'd0, exp_busy});
  end

  task automatic applyStimulus(input logic [7:0] data);
    @(negedge clk);
    bus.din      = data;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
  endtask

  // Called just after the accepting edge; samples mid-bit levels, frame length and
  // busy length, optionally pulsing tx_start mid-frame at clock poke_at.
  task automatic watchFrame(input string tag, input logic [10:0] bits, input int bclk,
                            input int done_at, input int poke_at, input logic [7:0] poke_din);
    int busy_cnt;
    int done_n;
    busy_cnt = bus.tx_busy ? 1 : 0;
    done_n   = -1;
    for (int n = 1; n <= done_at + 64 && done_n < 0; n++) begin
      @(posedge clk);
      #1;
      if (n == poke_at) begin
        bus.tx_start = 1'b1;
        bus.din      = poke_din;
      end
      if (n == poke_at + 1) bus.tx_start = 1'b0;
      if ((n % bclk) == bclk / 2 && (n / bclk) < NBITS)
        checkOutput({tag, "_bit"}, {31'd0, bus.tx}, {31'd0, bits[n / bclk]});
      if (bus.tx_done) done_n = n;
      else if (bus.tx_busy) busy_cnt++;
    end
    checkOutput({tag, "_done_at"},  done_n,   done_at);
    checkOutput({tag, "_busy_len"}, busy_cnt, done_at);
  endtask

  initial begin
    int   idle_busy;
    int   idle_done;
    logic found;
    bus.tx_start = 1'b0;
    bus.din      = 8'h00;

    #12;
    checkOutput("rst_tx",      {31'd0, bus.tx},      32'd1);
    checkOutput("rst_tx_done", {31'd0, bus.tx_done}, 32'd0);
    checkOutput("rst_tx_busy", {31'd0, bus.tx_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] frame 0xA5");
    applyStimulus(8'hA5);
    watchFrame("a5", BITS_A5, 16, FRAME_CLKS, -1, 8'h00);

    $display("[TB] back-to-back frame 0x00 from the tx_done cycle");
    checkOutput("gap_tx",      {31'd0, bus.tx},      32'd1);
    checkOutput("gap_tx_done", {31'd0, bus.tx_done}, 32'd1);
    bus.din      = 8'h00;
    bus.tx_start = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_start = 1'b0;
    checkOutput("b2b_busy", {31'd0, bus.tx_busy}, 32'd1);
    checkOutput("b2b_tx",   {31'd0, bus.tx},      32'd0);
    watchFrame("b2b_00", BITS_00, 16, FRAME_CLKS, -1, 8'h00);

    $display("[TB] tx_start 0x3C during data bits is ignored");
    repeat (3) @(negedge clk);
    applyStimulus(8'hA5);
    watchFrame("ignore", BITS_A5, 16, FRAME_CLKS, 40, 8'h3C);
    idle_busy = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (bus.tx_busy) idle_busy++;
    end
    checkOutput("no_second_frame", idle_busy, 0);

    $display("[TB] frame 0x07");
    applyStimulus(8'h07);
    watchFrame("d07", BITS_07, 16, FRAME_CLKS, -1, 8'h00);

    $display("[TB] reset during the 4th data bit");
    repeat (3) @(negedge clk);
    applyStimulus(8'hA5);
    repeat (70) @(posedge clk);
    #1;
    checkOutput("pre_rst_tx", {31'd0, bus.tx}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_tx",      {31'd0, bus.tx},      32'd1);
    checkOutput("mid_rst_tx_busy", {31'd0, bus.tx_busy}, 32'd0);
    checkOutput("mid_rst_tx_done", {31'd0, bus.tx_done}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_busy = 0;
    idle_done = 0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (bus.tx_busy) idle_busy++;
      if (bus.tx_done) idle_done++;
    end
    checkOutput("post_rst_busy", idle_busy, 0);
    checkOutput("post_rst_done", idle_done, 0);
    applyStimulus(8'h5A);
    watchFrame("d5a", BITS_5A, 16, FRAME_CLKS, -1, 8'h00);

    $display("[TB] s_tick every 4th clock, frame 0xFF");
    tick_div = 4;
    repeat (8) @(posedge clk);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(posedge clk);
      if (bus.s_tick) found = 1'b1;
    end
    checkOutput("tick_found", {31'd0, found}, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.din      = 8'hFF;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    watchFrame("slow_ff", BITS_FF, 64, SLOW_CLKS, -1, 8'h00);

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DBIT, default 8: number of data bits per frame.
REQ-002 SHALL have parameter BIT_WIDTH, default 16: s_tick pulses per start, data or parity bit.
REQ-003 SHALL have parameter SB_TICK, default 16: s_tick pulses per stop period (16 = 1 stop bit, 32 = 2).
REQ-004 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port s_tick  input  1  oversampling tick, one-clk pulse from the baud generator.
REQ-007 SHALL have port tx_start  input  1  start request, sampled only in IDLE.
REQ-008 SHALL have port din  input  DBIT  data word, captured on the cycle tx_start is accepted.
REQ-009 SHALL have port tx  output  1  serial line, registered, idle high.
REQ-010 SHALL have port tx_done  output  1  registered one-clk pulse at end of frame.
REQ-011 SHALL have port tx_busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP (plus PARITY per REQ-027); s_cnt counts s_tick pulses, n_cnt counts data bits.
REQ-013 IDLE: tx=1; on tx_start=1, next cycle state=START, b_reg=din, s_cnt=0; tx_start=0 keeps IDLE.
REQ-014 START: tx=0; on s_tick with s_cnt==BIT_WIDTH-1 go to DATA, s_cnt=0, n_cnt=0; otherwise s_cnt+1 per s_tick.
REQ-015 DATA: tx=b_reg[0] (LSB first); on s_tick with s_cnt==BIT_WIDTH-1, b_reg shifts right by one, s_cnt=0; n_cnt+1, or, if n_cnt==DBIT-1, exit to STOP (or PARITY), n_cnt=0.
REQ-016 STOP: tx=1; on s_tick with s_cnt==SB_TICK-1 go to IDLE and assert tx_done for exactly the next one clk.
REQ-017 tx SHALL be driven from a register, so state changes appear on tx one clk after the deciding edge and tx is glitch-free.
REQ-018 tx_start or din changes while tx_busy=1 SHALL be ignored; the frame in flight is unaffected.
REQ-019 tx_start in the cycle tx_done is high (state already IDLE) SHALL be accepted, giving back-to-back frames with a 1-clk idle gap.
REQ-020 s_tick coincident with tx_start in IDLE SHALL NOT be counted toward the start bit.
REQ-021 s_cnt width SHALL be clog2 of max(BIT_WIDTH, SB_TICK); n_cnt width SHALL be clog2(DBIT); counters SHALL never wrap past their terminal values.
REQ-022 Illegal state encodings SHALL return to IDLE on the next clk with tx=1.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, tx=1, tx_done=0, tx_busy=0, s_cnt=0, n_cnt=0, b_reg=0.
REQ-024 Reset mid-frame SHALL abort the frame with no tx_done pulse; the first tx_start after release starts a new full frame.

Configuration
REQ-025 Macro UART_TX_PARITY_EN SHALL select parity support.
REQ-026 Without the macro, DATA SHALL go directly to STOP and the frame SHALL be 1+DBIT bit periods plus SB_TICK ticks.
REQ-027 With the macro, DATA SHALL go to PARITY, where tx = even parity (XOR of captured din) for BIT_WIDTH ticks, then to STOP.

Structure
REQ-028 state_e (IDLE, START, DATA, STOP, PARITY) SHALL live in the shared states_pkg, common with the receiver; PARITY is unused when the macro is off.
REQ-029 The block SHALL be a single module with no sub-modules; the baud tick generator SHALL remain external.
REQ-030 Ports SHALL be carried on a uart_tx_IF interface with a DUT modport exposing DBIT, BIT_WIDTH and SB_TICK.

Verification (defaults, s_tick every clk unless stated)
REQ-031 din=8'hA5 with tx_start -> tx = 0, 1,0,1,0,0,1,0,1, 1 at 16 clks per bit; tx_done one clk after tick 160.
REQ-032 tx_start with din=8'h3C during the DATA state of an 8'hA5 frame -> frame is still 8'hA5 and no second frame is sent.
REQ-033 tx_start with din=8'h00 in the tx_done cycle -> next start bit begins after a 1-clk idle; line reads 0x00.
REQ-034 rst_n low during the 4th data bit -> tx=1, tx_busy=0, tx_done=0 the same cycle; no tx_done pulse follows.
REQ-035 UART_TX_PARITY_EN defined, din=8'h07 -> parity bit 1, tx_done after tick 176.
REQ-036 s_tick every 4th clk, din=8'hFF -> each bit lasts 64 clks; tx_busy stays high for 640 clks.
